out_fm_psum_acc: RTL and testbench

Read-modify-write partial-sum accumulator that sits directly upstream of the four-bank output feature-map buffer. It receives one product per lane per cycle from the MAC array, reads the current partial sum from the bank over the `inter_rd_*` port, adds the product, and writes the result back over the `inter_wr_*` port. Back-to-back updates to the same address are forwarded inside the block, so the MAC array can issue every cycle without stalling.

---
 rtl/out_fm_psum_acc.sv | 177 +++++++++++++++++
 tb/tb_out_fm_psum_acc.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_fm_psum_acc.sv
// Read-modify-write partial-sum accumulator for the 4-bank output feature-map buffer.
// Define OUT_FM_PSUM_ACC_SAT_EN for a saturating add instead of wrap-around.
module out_fm_psum_acc #(
   parameter int AW = 16,
   parameter int DW = 32,
   parameter int RL = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_data0,
   input  logic [DW-1:0] in_data1,
   input  logic [DW-1:0] in_data2,
   input  logic [DW-1:0] in_data3,
   input  logic          in_first,
   input  logic          in_last,
   output logic [AW-1:0] inter_rd_addr0,
   output logic [AW-1:0] inter_rd_addr1,
   output logic [AW-1:0] inter_rd_addr2,
   output logic [AW-1:0] inter_rd_addr3,
   input  logic [DW-1:0] inter_rd_data0,
   input  logic [DW-1:0] inter_rd_data1,
   input  logic [DW-1:0] inter_rd_data2,
   input  logic [DW-1:0] inter_rd_data3,
   output logic [AW-1:0] inter_wr_addr0,
   output logic [AW-1:0] inter_wr_addr1,
   output logic [AW-1:0] inter_wr_addr2,
   output logic [AW-1:0] inter_wr_addr3,
   output logic [DW-1:0] inter_wr_data0,
   output logic [DW-1:0] inter_wr_data1,
   output logic [DW-1:0] inter_wr_data2,
   output logic [DW-1:0] inter_wr_data3,
   output logic          inter_wr_ena0,
   output logic          inter_wr_ena1,
   output logic          inter_wr_ena2,
   output logic          inter_wr_ena3,
   output logic          busy,
   output logic          done
);

   localparam int NL = 4;
   localparam int HN = RL + 1;

   logic [DW-1:0] in_d [NL];
   logic [DW-1:0] rd_d [NL];

   logic          s_vld   [RL];
   logic [AW-1:0] s_addr  [RL];
   logic          s_first [RL];
   logic          s_last  [RL];
   logic [DW-1:0] s_data  [RL][NL];

   logic          sa_vld;
   logic [AW-1:0] sa_addr;
   logic          sa_last;
   logic [DW-1:0] sa_data [NL];

   logic          h_vld  [HN];
   logic [AW-1:0] h_addr [HN];
   logic [DW-1:0] h_data [HN][NL];

   logic          done_q;
   logic [DW-1:0] opnd [NL];
   logic [DW-1:0] res  [NL];

   assign in_d[0] = in_data0;
   assign in_d[1] = in_data1;
   assign in_d[2] = in_data2;
   assign in_d[3] = in_data3;
   assign rd_d[0] = inter_rd_data0;
   assign rd_d[1] = inter_rd_data1;
   assign rd_d[2] = inter_rd_data2;
   assign rd_d[3] = inter_rd_data3;

   assign inter_rd_addr0 = in_addr;
   assign inter_rd_addr1 = in_addr;
   assign inter_rd_addr2 = in_addr;
   assign inter_rd_addr3 = in_addr;

   assign inter_wr_addr0 = sa_addr;
   assign inter_wr_addr1 = sa_addr;
   assign inter_wr_addr2 = sa_addr;
   assign inter_wr_addr3 = sa_addr;
   assign inter_wr_data0 = sa_data[0];
   assign inter_wr_data1 = sa_data[1];
   assign inter_wr_data2 = sa_data[2];
   assign inter_wr_data3 = sa_data[3];
   assign inter_wr_ena0  = sa_vld;
   assign inter_wr_ena1  = sa_vld;
   assign inter_wr_ena2  = sa_vld;
   assign inter_wr_ena3  = sa_vld;
   assign done           = done_q;

   function automatic logic [DW-1:0] add_f(
      input logic [DW-1:0] a,
      input logic [DW-1:0] b
   );
      logic [DW-1:0] sum;
      sum = a + b;
`ifdef OUT_FM_PSUM_ACC_SAT_EN
      // Overflow only when both operands share a sign the result lacks
      if (a[DW-1] == b[DW-1] && sum[DW-1] != a[DW-1])
         sum = a[DW-1] ? {1'b1, {(DW-1){1'b0}}}
                       : {1'b0, {(DW-1){1'b1}}};
`endif
      return sum;
   endfunction

   // Oldest history entry first so the youngest match wins
   always_comb begin
      for (int l = 0; l < NL; l++) opnd[l] = rd_d[l];
      for (int j = HN - 1; j >= 0; j--) begin
         if (h_vld[j] && h_addr[j] == s_addr[RL-1])
            for (int l = 0; l < NL; l++) opnd[l] = h_data[j][l];
      end
      if (sa_vld && sa_addr == s_addr[RL-1])
         for (int l = 0; l < NL; l++) opnd[l] = sa_data[l];
      for (int l = 0; l < NL; l++)
         res[l] = s_first[RL-1] ? s_data[RL-1][l]
                                : add_f(opnd[l], s_data[RL-1][l]);
   end

   always_comb begin
      busy = sa_vld;
      for (int i = 0; i < RL; i++) busy = busy | s_vld[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RL; i++) begin
            s_vld[i]   <= 1'b0;
            s_addr[i]  <= '0;
            s_first[i] <= 1'b0;
            s_last[i]  <= 1'b0;
            for (int l = 0; l < NL; l++) s_data[i][l] <= '0;
         end
         sa_vld  <= 1'b0;
         sa_addr <= '0;
         sa_last <= 1'b0;
         for (int l = 0; l < NL; l++) sa_data[l] <= '0;
         for (int j = 0; j < HN; j++) begin
            h_vld[j]  <= 1'b0;
            h_addr[j] <= '0;
            for (int l = 0; l < NL; l++) h_data[j][l] <= '0;
         end
         done_q <= 1'b0;
      end else begin
         s_vld[0]   <= in_valid;
         s_addr[0]  <= in_addr;
         s_first[0] <= in_first;
         s_last[0]  <= in_last;
         for (int l = 0; l < NL; l++) s_data[0][l] <= in_d[l];
         for (int i = 1; i < RL; i++) begin
            s_vld[i]   <= s_vld[i-1];
            s_addr[i]  <= s_addr[i-1];
            s_first[i] <= s_first[i-1];
            s_last[i]  <= s_last[i-1];
            for (int l = 0; l < NL; l++) s_data[i][l] <= s_data[i-1][l];
         end
         sa_vld  <= s_vld[RL-1];
         sa_addr <= s_addr[RL-1];
         sa_last <= s_last[RL-1];
         for (int l = 0; l < NL; l++) sa_data[l] <= res[l];
         h_vld[0]  <= sa_vld;
         h_addr[0] <= sa_addr;
         for (int l = 0; l < NL; l++) h_data[0][l] <= sa_data[l];
         for (int j = 1; j < HN; j++) begin
            h_vld[j]  <= h_vld[j-1];
            h_addr[j] <= h_addr[j-1];
            for (int l = 0; l < NL; l++) h_data[j][l] <= h_data[j-1][l];
         end
         done_q <= sa_vld & sa_last;
      end
   end

endmodule

// File: tb/tb_out_fm_psum_acc.sv
// Scoreboard bench for out_fm_psum_acc with a read-first bank model (RL=2).
// Expected sums come from a per-address sequential model of the accumulation.
module tb_out_fm_psum_acc;

   localparam int RL = 2;

   typedef struct {
      int               cyc;
      logic [15:0]      addr;
      logic [3:0][31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_addr;
   logic [31:0] ind [4];
   logic        in_first;
   logic        in_last;
   logic [15:0] rda [4];
   logic [31:0] rdd [4];
   logic [15:0] wa  [4];
   logic [31:0] wd  [4];
   logic [3:0]  we;
   logic        busy;
   logic        done;

   logic [31:0] bmem [4][256] = '{default: '0};
   logic [31:0] mdl  [4][256] = '{default: '0};
   logic [31:0] rp   [4][RL];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   int  cyc = 0;
   int  total = 0;
   int  bad = 0;
   wr_t wq [$];
   int  dq [$];
   wr_t me;

   out_fm_psum_acc #(.AW(16), .DW(32), .RL(RL)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_addr(in_addr),
      .in_data0(ind[0]), .in_data1(ind[1]),
      .in_data2(ind[2]), .in_data3(ind[3]),
      .in_first(in_first), .in_last(in_last),
      .inter_rd_addr0(rda[0]), .inter_rd_addr1(rda[1]),
      .inter_rd_addr2(rda[2]), .inter_rd_addr3(rda[3]),
      .inter_rd_data0(rdd[0]), .inter_rd_data1(rdd[1]),
      .inter_rd_data2(rdd[2]), .inter_rd_data3(rdd[3]),
      .inter_wr_addr0(wa[0]), .inter_wr_addr1(wa[1]),
      .inter_wr_addr2(wa[2]), .inter_wr_addr3(wa[3]),
      .inter_wr_data0(wd[0]), .inter_wr_data1(wd[1]),
      .inter_wr_data2(wd[2]), .inter_wr_data3(wd[3]),
      .inter_wr_ena0(we[0]), .inter_wr_ena1(we[1]),
      .inter_wr_ena2(we[2]), .inter_wr_ena3(we[3]),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Read-first bank: read registers sample memory before this edge's write
   always @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         rp[l][0] <= bmem[l][rda[l][7:0]];
         for (int k = 1; k < RL; k++) rp[l][k] <= rp[l][k-1];
         if (we[l]) bmem[l][wa[l][7:0]] <= wd[l];
         if (pl_en) bmem[l][pl_addr] <= pl_data;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_rd
      assign rdd[g] = rp[g][RL-1];
   end

   task automatic chk(input string n, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h @cyc %0d", n, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] acc(input logic [31:0] a,
                                       input logic [31:0] b);
      longint s;
      logic [63:0] r;
      s = longint'($signed(a)) + longint'($signed(b));
`ifdef OUT_FM_PSUM_ACC_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      r = s;
      return r[31:0];
   endfunction

   task automatic preload(input logic [7:0] a, input logic [31:0] v);
      @(negedge clk);
      pl_en = 1'b1;
      pl_addr = a;
      pl_data = v;
      for (int l = 0; l < 4; l++) mdl[l][a] = v;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_first = 1'b0;
         in_last = 1'b0;
      end
   endtask

   task automatic beat(input logic [15:0] a, input logic [3:0][31:0] d,
                       input bit f, input bit l);
      wr_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_addr = a;
      in_first = f;
      in_last = l;
      e.cyc = cyc + RL + 1;
      e.addr = a;
      for (int k = 0; k < 4; k++) begin
         ind[k] = d[k];
         e.d[k] = f ? d[k] : acc(mdl[k][a[7:0]], d[k]);
         mdl[k][a[7:0]] = e.d[k];
      end
      wq.push_back(e);
      if (l) dq.push_back(cyc + RL + 2);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((wq.size() != 0 || dq.size() != 0) && n < 50) begin
         idle(1);
         n++;
      end
      idle(2);
      chk("drain_wr", 64'(wq.size()), 64'd0);
      chk("drain_done", 64'(dq.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_no_wr", 64'(we), 64'd0);
      end else begin
         if (we != 4'b0000) begin
            chk("wr_expected", 64'(wq.size() != 0), 64'd1);
            chk("wr_ena_all", 64'(we), 64'hf);
            if (wq.size() != 0) begin
               me = wq.pop_front();
               chk("wr_cyc", 64'(cyc), 64'(me.cyc));
               for (int l = 0; l < 4; l++) begin
                  chk("wr_addr", 64'(wa[l]), 64'(me.addr));
                  chk("wr_data", 64'(wd[l]), 64'(me.d[l]));
               end
            end
         end
         if (done) begin
            chk("done_expected", 64'(dq.size() != 0), 64'd1);
            if (dq.size() != 0) chk("done_cyc", 64'(cyc), 64'(dq.pop_front()));
         end
      end
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_addr = 16'h1234;
      in_first = 1'b0;
      in_last = 1'b0;
      for (int l = 0; l < 4; l++) ind[l] = '0;
      #2;
      chk("rst_wr_ena", 64'(we), 64'd0);
      chk("rst_wr_addr", 64'(wa[0]), 64'd0);
      chk("rst_wr_data", 64'(wd[0]), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rd_addr_comb", 64'(rda[2]), 64'h1234);
      in_addr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      preload(8'd5, 32'd10);
      beat(16'd5, {4{32'd3}}, 1'b0, 1'b1);
      drain();

      preload(8'd7, 32'd100);
      beat(16'd7, {4{32'd9}}, 1'b1, 1'b0);
      drain();

      beat(16'd4, {4{32'd1}}, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) beat(16'd4, {4{32'd1}}, 1'b0, i == 3);
      drain();
      chk("bank4_final", 64'(bmem[0][4]), 64'd5);

      beat(16'd2, {4{32'd1}}, 1'b1, 1'b0);
      idle(3);
      beat(16'd2, {4{32'd1}}, 1'b0, 1'b0);
      drain();

      preload(8'd9, 32'h7fffffff);
      beat(16'd9, {4{32'd1}}, 1'b0, 1'b0);
      drain();
`ifdef OUT_FM_PSUM_ACC_SAT_EN
      chk("sat_bank", 64'(bmem[1][9]), 64'h7fffffff);
`else
      chk("wrap_bank", 64'(bmem[1][9]), 64'h80000000);
`endif

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) idle(1);
         else beat(16'($urandom_range(7)),
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(5) == 0, $urandom_range(15) == 0);
      end
      drain();

      for (int i = 0; i < 3; i++) beat(16'd4, {4{32'd100}}, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_wr_ena", 64'(we), 64'd0);
      wq.delete();
      dq.delete();
      for (int l = 0; l < 4; l++)
         for (int a = 0; a < 256; a++) mdl[l][a] = bmem[l][a];
      repeat (2) @(negedge clk);
      rst = 1'b0;
      beat(16'd4, {4{32'd1}}, 1'b0, 1'b1);
      beat(16'd4, {4{32'd2}}, 1'b0, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
